// File: rtl/fifo_pkg.sv
// Shared definitions for the fifo and its write-side arbiter.
package fifo_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin search: first requester after `last`, wrapping, with `last` itself tried last.
module rr_pick #(
    parameter int NREQ  = 4,
    parameter int IDX_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] last,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    int cand;

    // Walk from farthest to nearest so the nearest hit overwrites earlier ones.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = 0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = (int'(last) + k) % NREQ;
            if (req[IDX_W'(cand)]) begin
                found = 1'b1;
                idx   = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-limited arbiter feeding several requesters into one shared fifo.
module fifo_wr_arbiter
    import fifo_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*WIDTH-1:0]     req_data,
    output logic [NREQ-1:0]           ack,
    input  logic                      fifo_full,
    output logic                      write_en,
    output logic [WIDTH-1:0]          write_data,
    output logic                      busy,
    output logic [$clog2(NREQ)-1:0]   owner
);

    localparam int IDX_W = $clog2(NREQ);
    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    arb_state_t       state;
    logic [IDX_W-1:0] owner_r;
    logic [IDX_W-1:0] last;
    logic [CNT_W-1:0] count;

    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;
    logic [IDX_W-1:0] pick_from;
    logic             owner_req;
    logic             last_beat;
    logic             grant_end;

    assign busy      = (state == BURST);
    assign owner     = owner_r;
    assign owner_req = req[owner_r];
    assign write_en  = busy & owner_req & ~fifo_full;
    assign last_beat = (count == CNT_W'(MAX_BURST - 1));
    assign grant_end = busy & (~owner_req | (write_en & last_beat));

    // At a release the search starts after the outgoing owner, so it can only
    // win again when nobody else is asking.
    assign pick_from = busy ? owner_r : last;

    always_comb begin
        ack          = '0;
        ack[owner_r] = write_en;
    end

    assign write_data = busy ? req_data[int'(owner_r)*WIDTH +: WIDTH] : '0;

    rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req   (req),
        .last  (pick_from),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            owner_r <= '0;
            count   <= '0;
            last    <= IDX_W'(NREQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        state   <= BURST;
                        owner_r <= pick_idx;
                        count   <= '0;
                    end
                end
                BURST: begin
                    if (grant_end) begin
                        last  <= owner_r;
                        count <= '0;
                        if (pick_found) begin
                            owner_r <= pick_idx;
                        end else begin
                            state   <= IDLE;
                            owner_r <= '0;
                        end
                    end else if (write_en) begin
                        count <= count + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    owner_r <= '0;
                    count   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: fixed vector table, directed corner sequences and random traffic vs a reference model.
module tb_fifo_wr_arbiter;

    localparam int WIDTH     = 8;
    localparam int NREQ      = 4;
    localparam int MAX_BURST = 4;
    localparam int DEPTH     = 16;
    localparam int QSZ       = 64;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       ack;
    logic                  fifo_full;
    logic                  write_en;
    logic [WIDTH-1:0]      write_data;
    logic                  busy;
    logic [1:0]            owner;

    fifo_wr_arbiter #(
        .WIDTH     (WIDTH),
        .NREQ      (NREQ),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_data   (req_data),
        .ack        (ack),
        .fifo_full  (fifo_full),
        .write_en   (write_en),
        .write_data (write_data),
        .busy       (busy),
        .owner      (owner)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: grant holder, words written in this grant, rotation pointer.
    bit             m_busy  = 1'b0;
    int             m_owner = 0;
    int             m_beats = 0;
    int             m_last  = NREQ - 1;
    bit             e_busy, e_we;
    int             e_owner;
    logic [7:0]     e_wd;
    logic [3:0]     e_ack;

    task automatic model_eval();
        e_busy  = m_busy;
        e_owner = m_owner;
        e_we    = m_busy && req[m_owner] && !fifo_full;
        e_wd    = m_busy ? req_data[m_owner*WIDTH +: WIDTH] : 8'h00;
        e_ack   = e_we ? 4'(1 << m_owner) : 4'b0000;
    endtask

    task automatic model_step();
        bit release_now;
        model_eval();
        if (rst) begin
            m_busy = 0; m_owner = 0; m_beats = 0; m_last = NREQ - 1;
        end else begin
            release_now = m_busy && (!req[m_owner] || (e_we && m_beats == MAX_BURST - 1));
            if (m_busy && !release_now) begin
                if (e_we) m_beats++;
            end else begin
                if (m_busy) m_last = m_owner;
                m_busy = 0; m_owner = 0; m_beats = 0;
                for (int k = 1; k <= NREQ; k++) begin
                    if (req[(m_last + k) % NREQ]) begin
                        m_busy  = 1;
                        m_owner = (m_last + k) % NREQ;
                        break;
                    end
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    // Requester word queues, DUT write log, shared-fifo occupancy.
    logic [7:0] words [NREQ][QSZ];
    int         head [NREQ];
    int         tail [NREQ];
    logic [7:0] log_data [256];
    int         log_owner [256];
    int         n_log;
    int         stalls;
    int         fifo_cnt;
    int         wr_err;
    bit         use_fifo;

    task automatic clear_all();
        for (int i = 0; i < NREQ; i++) begin head[i] = 0; tail[i] = 0; end
        n_log = 0; stalls = 0; fifo_cnt = 0; wr_err = 0; use_fifo = 0;
    endtask

    task automatic push(input int i, input logic [7:0] w);
        words[i][tail[i] % QSZ] = w;
        tail[i]++;
    endtask

    task automatic check_outputs(input string tag);
        model_eval();
        chk({tag, " busy"},       32'(busy),       32'(e_busy));
        chk({tag, " owner"},      32'(owner),      32'(e_owner));
        chk({tag, " write_en"},   32'(write_en),   32'(e_we));
        chk({tag, " write_data"}, 32'(write_data), 32'(e_wd));
        chk({tag, " ack"},        32'(ack),        32'(e_ack));
        if (write_en === 1'b1 && n_log < 256) begin
            log_data[n_log]  = write_data;
            log_owner[n_log] = int'(owner);
            n_log++;
        end
        if (busy === 1'b1 && fifo_full && write_en === 1'b0) stalls++;
        if (write_en === 1'b1 && fifo_full) wr_err++;
    endtask

    task automatic queue_cycle(input bit r, input bit full_in);
        logic [3:0] pop;
        bit         accept;
        rst = r;
        for (int i = 0; i < NREQ; i++) begin
            req[i] = (head[i] != tail[i]);
            req_data[i*WIDTH +: WIDTH] = (head[i] != tail[i]) ? words[i][head[i] % QSZ] : 8'h00;
        end
        fifo_full = use_fifo ? (fifo_cnt >= DEPTH) : full_in;
        #3;
        check_outputs("seq");
        pop    = e_ack;
        accept = (write_en === 1'b1) && !fifo_full;
        tick();
        for (int i = 0; i < NREQ; i++) if (pop[i]) head[i]++;
        if (accept) fifo_cnt++;
    endtask

    task automatic reset_cycle();
        clear_all();
        queue_cycle(1'b1, 1'b0);
        clear_all();
    endtask

    typedef struct {
        bit         rst;
        logic [3:0] req;
        bit         full;
        bit         busy;
        logic [1:0] owner;
        bit         we;
        logic [3:0] ack;
        logic [7:0] wd;
    } vec_t;

    vec_t tbl [10];

    initial begin
        rst = 1'b1; req = '0; req_data = '0; fifo_full = 1'b0;
        clear_all();
        @(posedge clk); #1;

        //            rst  req      full busy owner we ack      wd
        tbl[0] = '{1'b1, 4'b1111, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 8'h00};
        tbl[1] = '{1'b0, 4'b0100, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 8'h00};
        tbl[2] = '{1'b0, 4'b0100, 1'b0, 1'b1, 2'd2, 1'b1, 4'b0100, 8'hD2};
        tbl[3] = '{1'b1, 4'b0100, 1'b0, 1'b1, 2'd2, 1'b1, 4'b0100, 8'hD2};
        tbl[4] = '{1'b0, 4'b1111, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 8'h00};
        tbl[5] = '{1'b0, 4'b1111, 1'b0, 1'b1, 2'd0, 1'b1, 4'b0001, 8'hD0};
        tbl[6] = '{1'b0, 4'b1111, 1'b1, 1'b1, 2'd0, 1'b0, 4'b0000, 8'hD0};
        tbl[7] = '{1'b0, 4'b0000, 1'b0, 1'b1, 2'd0, 1'b0, 4'b0000, 8'hD0};
        tbl[8] = '{1'b0, 4'b0010, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 8'h00};
        tbl[9] = '{1'b0, 4'b0011, 1'b0, 1'b1, 2'd1, 1'b1, 4'b0010, 8'hD1};

        req_data = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
        for (int v = 0; v < 10; v++) begin
            rst = tbl[v].rst; req = tbl[v].req; fifo_full = tbl[v].full;
            #3;
            chk($sformatf("vec%0d busy", v),       32'(busy),       32'(tbl[v].busy));
            chk($sformatf("vec%0d owner", v),      32'(owner),      32'(tbl[v].owner));
            chk($sformatf("vec%0d write_en", v),   32'(write_en),   32'(tbl[v].we));
            chk($sformatf("vec%0d ack", v),        32'(ack),        32'(tbl[v].ack));
            chk($sformatf("vec%0d write_data", v), 32'(write_data), 32'(tbl[v].wd));
            tick();
        end

        // All four requesting: 4-beat grants rotate 0,1,2,3,0 back to back.
        reset_cycle();
        for (int i = 0; i < NREQ; i++)
            for (int k = 0; k < 8; k++) push(i, 8'(i*16 + k));
        for (int c = 0; c < 21; c++) queue_cycle(1'b0, 1'b0);
        chk("rr writes in 21 cycles", 32'(n_log), 32'd20);
        for (int k = 0; k < 20; k++) begin
            chk($sformatf("rr owner[%0d]", k), 32'(log_owner[k]), 32'((k/4) % 4));
            chk($sformatf("rr data[%0d]", k),  32'(log_data[k]),  32'(((k/4) % 4)*16 + (k/16)*4 + k%4));
        end

        // Two-word request from requester 2 then back to idle.
        reset_cycle();
        push(2, 8'hA1); push(2, 8'hA2);
        for (int c = 0; c < 5; c++) queue_cycle(1'b0, 1'b0);
        chk("short writes", 32'(n_log), 32'd2);
        chk("short word0", 32'(log_data[0]), 32'hA1);
        chk("short word1", 32'(log_data[1]), 32'hA2);
        chk("short idle busy", 32'(busy), 32'd0);

        // Owner 1 stalled by a full fifo for three cycles after two beats.
        reset_cycle();
        for (int k = 0; k < 4; k++) push(1, 8'(8'h50 + k));
        for (int c = 0; c < 9; c++) queue_cycle(1'b0, (c >= 3 && c <= 5));
        chk("stall writes", 32'(n_log), 32'd4);
        chk("stall cycles", 32'(stalls), 32'd3);
        chk("stall last word", 32'(log_data[3]), 32'h53);
        chk("stall idle busy", 32'(busy), 32'd0);

        // Owner 0 runs dry on its fourth beat: one release, owner 1 follows.
        reset_cycle();
        for (int k = 0; k < 4; k++) push(0, 8'(8'h10 + k));
        for (int k = 0; k < 3; k++) push(1, 8'(8'h20 + k));
        for (int c = 0; c < 10; c++) queue_cycle(1'b0, 1'b0);
        chk("handoff writes", 32'(n_log), 32'd7);
        for (int k = 0; k < 7; k++)
            chk($sformatf("handoff data[%0d]", k), 32'(log_data[k]),
                (k < 4) ? 32'(8'h10 + k) : 32'(8'h20 + k - 4));

        // Twenty words into a 16-deep fifo that is never read.
        reset_cycle();
        use_fifo = 1'b1;
        for (int i = 0; i < NREQ; i++)
            for (int k = 0; k < 5; k++) push(i, 8'(i*16 + k));
        for (int c = 0; c < 40; c++) queue_cycle(1'b0, 1'b0);
        chk("fifo writes", 32'(n_log), 32'(DEPTH));
        chk("fifo occupancy", 32'(fifo_cnt), 32'(DEPTH));
        chk("fifo write_error", 32'(wr_err), 32'd0);

        // Random traffic, random full and occasional reset against the model.
        reset_cycle();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NREQ; i++)
                if ($urandom_range(0, 3) == 0 && (tail[i] - head[i]) < QSZ - 4)
                    push(i, 8'($urandom));
            queue_cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) == 0));
            n_log = 0;
        end
        chk("random write_error", 32'(wr_err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning data word width, matching the shared fifo.
REQ-002 SHALL have parameter NREQ, default 4, meaning number of requesters (2..8).
REQ-003 SHALL have parameter MAX_BURST, default 4, meaning maximum accepted words per grant (1..16).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on posedge clk.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port req, input, NREQ bits: requester i has a valid word pending.
REQ-007 SHALL have port req_data, input, NREQ*WIDTH bits: requester i word in bits [i*WIDTH +: WIDTH].
REQ-008 SHALL have port ack, output, NREQ bits: one-hot; the word of requester i is consumed this cycle.
REQ-009 SHALL have port fifo_full, input, 1 bit: full flag from the shared fifo.
REQ-010 SHALL have port write_en, output, 1 bit: write strobe to the shared fifo.
REQ-011 SHALL have port write_data, output, WIDTH bits: word to the shared fifo.
REQ-012 SHALL have port busy, output, 1 bit: the state is BURST.
REQ-013 SHALL have port owner, output, clog2(NREQ) bits: current grant holder; 0 when idle.

Function
REQ-014 SHALL implement FSM states IDLE and BURST, with registered owner, beat counter and round-robin pointer last.
REQ-015 SHALL make write_en, write_data and ack combinational from registered state, so that write and acknowledge occur in the same cycle the fifo samples them (zero added latency).
REQ-016 SHALL set write_en = busy & req[owner] & ~fifo_full, with ack[owner] = write_en and all other ack bits 0.
REQ-017 SHALL set write_data = req_data[owner] whenever busy, and 0 otherwise.
REQ-018 SHALL pick the next owner as the first requester with req set, searching last+1, last+2, ... modulo NREQ, with last itself searched last.
REQ-019 SHALL, in IDLE with any req set, go to BURST with the picked owner and beat count 0; with no req set, stay in IDLE.
REQ-020 SHALL increment the beat count on each write_en; while fifo_full=1 with req[owner]=1, hold count and owner (stall, no write).
REQ-021 SHALL end a grant at the edge where either write_en=1 with count=MAX_BURST-1, or req[owner]=0.
REQ-022 SHALL, when a grant ends, set last=owner, then re-arbitrate at the same edge: go to BURST with a new owner and count 0 if any req is set, otherwise go to IDLE (no idle bubble between grants).
REQ-023 SHALL permit the ending owner to win again only if no other requester has req set.
REQ-024 SHALL treat req dropping on the same edge as the final beat identically to REQ-021/REQ-022: a single release.
REQ-025 SHALL never assert write_en while fifo_full=1, so the fifo write_error flag can never be raised by this block.

Reset
REQ-026 SHALL, on rst=1 at any clock edge including mid-burst, set state IDLE, owner 0, count 0 and last NREQ-1, so that requester 0 wins first.
REQ-027 SHALL hold busy=0, write_en=0, ack=0 and write_data=0 during and immediately after reset.

Structure
REQ-028 SHALL place the state enum (IDLE, BURST) and the default WIDTH constant in shared package fifo_pkg, used by both fifo and arbiter.
REQ-029 SHALL implement the round-robin search as a combinational sub-module rr_pick (inputs req and last; outputs found and idx).
REQ-030 SHALL keep the implementation at 120-400 RTL lines with no memories.

Verification
REQ-031 SHALL cover this scenario: after reset, req=4'b1111 held, fifo_full=0 -> owners 0,1,2,3,0 in turn, 4 writes each, no gap cycles, ack one-hot.
REQ-032 SHALL cover this scenario: req=4'b0100 pulsed for 2 cycles with data 8'hA1, 8'hA2 -> 2 writes of A1, A2, then IDLE, busy=0.
REQ-033 SHALL cover this scenario: owner 1 at beat 2, fifo_full=1 for 3 cycles -> write_en=0 and ack=0 for 3 cycles, count held; after full clears, 2 more beats then release.
REQ-034 SHALL cover this scenario: req=4'b0011, owner 0 drops req at the same edge as its 4th beat -> single release, owner 1 next cycle, no duplicate write.
REQ-035 SHALL cover this scenario: rst=1 mid-burst at owner 2, beat 1 -> next cycle busy=0, write_en=0; with req=4'b1111 the first grant goes to 0.
REQ-036 SHALL cover this scenario: arbiter driving a fifo of DEPTH=16 with no reads, 20 words offered -> exactly 16 writes, fifo write_error stays 0.
